// File: rtl/sa_pkg.sv
// Shared defaults and width rules for the systolic-array operand buffers.
package sa_pkg;

  localparam int unsigned SA_LANES      = 32;
  localparam int unsigned SA_DEPTH      = 32;
  localparam int unsigned SA_DEPTH_LOG2 = 5;
  localparam int unsigned SA_BWIDTH     = 8;

  typedef logic [SA_BWIDTH-1:0] sa_elem_t;

  // Pointers and counts carry one extra wrap bit so full and empty stay distinct.
  function automatic int unsigned sa_ptr_w(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Per-lane {valid, data} delay line; data is forced to zero whenever valid is low.
module sa_skew_line #(
  parameter int unsigned DELAY  = 1,
  parameter int unsigned BWIDTH = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              FLUSH,
  input  logic              in_valid,
  input  logic [BWIDTH-1:0] in_data,
  output logic              out_valid,
  output logic [BWIDTH-1:0] out_data,
  output logic              busy
);

  if (DELAY == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, CLK, RSTn, FLUSH};
    assign out_valid   = in_valid;
    assign out_data    = in_valid ? in_data : '0;
    assign busy        = 1'b0;
  end else begin : g_delay
    logic [DELAY-1:0]  vld;
    logic [BWIDTH-1:0] dat [DELAY];

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        vld <= '0;
        for (int unsigned i = 0; i < DELAY; i++) dat[i] <= '0;
      end else if (FLUSH) begin
        vld <= '0;
        for (int unsigned i = 0; i < DELAY; i++) dat[i] <= '0;
      end else begin
        vld[0] <= in_valid;
        dat[0] <= in_valid ? in_data : '0;
        for (int unsigned i = 1; i < DELAY; i++) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end

    assign out_valid = vld[DELAY-1];
    assign out_data  = vld[DELAY-1] ? dat[DELAY-1] : '0;
    assign busy      = |vld;
  end

endmodule

// File: rtl/sa_skew_fifo.sv
// Row FIFO feeding one edge of the PE array, replaying popped rows with a per-lane diagonal skew.
// Optional sticky error flags are built only when SA_SKEW_FIFO_ERR_EN is defined.
module sa_skew_fifo
  import sa_pkg::*;
#(
  parameter int unsigned LANES      = SA_LANES,
  parameter int unsigned DEPTH      = SA_DEPTH,
  parameter int unsigned DEPTH_LOG2 = SA_DEPTH_LOG2,
  parameter int unsigned BWIDTH     = SA_BWIDTH,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    FLUSH,
  input  logic                    PUSHE,
  input  logic [LANES*BWIDTH-1:0] D_in,
  input  logic                    POPE,
  output logic                    IS_EMPTY,
  output logic                    IS_FULL,
  output logic                    ALMOST_FULL,
  output logic [DEPTH_LOG2:0]     COUNT,
  output logic                    BUSY,
  output logic [LANES*BWIDTH-1:0] D_out,
  output logic [LANES-1:0]        D_VALID,
  output logic                    ERR_OVF,
  output logic                    ERR_UDF
);

  localparam int unsigned PW = sa_ptr_w(DEPTH_LOG2);
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic [PW-1:0]           front, rear, count;
  logic [LANES*BWIDTH-1:0] mem [DEPTH];
  logic [LANES*BWIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic [LANES-1:0]        lane_busy;
  logic                    pop_ok, push_ok;

  assign IS_EMPTY    = (front == rear);
  assign IS_FULL     = (front[PW-2:0] == rear[PW-2:0]) && (front[PW-1] != rear[PW-1]);
  assign ALMOST_FULL = (count >= AF_LEVEL);
  assign COUNT       = count;

  assign pop_ok  = POPE & ~IS_EMPTY;
  assign push_ok = PUSHE & (~IS_FULL | pop_ok);

  always_ff @(posedge CLK) begin
    if (push_ok && !FLUSH) mem[rear[PW-2:0]] <= D_in;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      front    <= '0;
      rear     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (FLUSH) begin
      front    <= '0;
      rear     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (pop_ok)  front <= front + ONE;
      if (push_ok) rear  <= rear + ONE;
      count    <= count + PW'(push_ok) - PW'(pop_ok);
      rd_valid <= pop_ok;
      rd_data  <= pop_ok ? mem[front[PW-2:0]] : '0;
    end
  end

  // Lane 0 is taken straight from the read register; lane i adds i cycles on top.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sa_skew_line #(
      .DELAY  (i),
      .BWIDTH (BWIDTH)
    ) u_line (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .FLUSH     (FLUSH),
      .in_valid  (rd_valid),
      .in_data   (rd_data[i*BWIDTH +: BWIDTH]),
      .out_valid (D_VALID[i]),
      .out_data  (D_out[i*BWIDTH +: BWIDTH]),
      .busy      (lane_busy[i])
    );
  end

  assign BUSY = ~IS_EMPTY | rd_valid | (|lane_busy);

`ifdef SA_SKEW_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (PUSHE & IS_FULL & ~pop_ok) ovf_q <= 1'b1;
      if (POPE & IS_EMPTY)           udf_q <= 1'b1;
    end
  end

  assign ERR_OVF = ovf_q;
  assign ERR_UDF = udf_q;
`else
  assign ERR_OVF = 1'b0;
  assign ERR_UDF = 1'b0;
`endif

endmodule

// File: tb/tb_sa_skew_fifo.sv
// Directed bench for sa_skew_fifo with 4 lanes x 32 rows, plus a small row-queue/skew model.
module tb_sa_skew_fifo;
  import sa_pkg::*;

  localparam int unsigned L = 4;
  localparam int unsigned D = 32;

  logic          CLK, RSTn, FLUSH, PUSHE, POPE;
  logic [L*8-1:0] D_in, D_out;
  logic          IS_EMPTY, IS_FULL, ALMOST_FULL, BUSY, ERR_OVF, ERR_UDF;
  logic [5:0]    COUNT;
  logic [L-1:0]  D_VALID;

  sa_skew_fifo #(
    .LANES      (L),
    .DEPTH      (D),
    .DEPTH_LOG2 (5),
    .BWIDTH     (8),
    .AF_MARGIN  (2)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .FLUSH       (FLUSH),
    .PUSHE       (PUSHE),
    .D_in        (D_in),
    .POPE        (POPE),
    .IS_EMPTY    (IS_EMPTY),
    .IS_FULL     (IS_FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .COUNT       (COUNT),
    .BUSY        (BUSY),
    .D_out       (D_out),
    .D_VALID     (D_VALID),
    .ERR_OVF     (ERR_OVF),
    .ERR_UDF     (ERR_UDF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] q [$];
  logic        pv [L];
  logic [31:0] pr [L];
  bit          m_ovf, m_udf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] row(input int k);
    logic [31:0] r;
    for (int i = 0; i < L; i++) r[i*8 +: 8] = sa_elem_t'(k + i);
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < L; i++) begin
      pv[i] = 1'b0;
      pr[i] = '0;
    end
  endtask

  task automatic check_all();
    logic [31:0] e_out;
    logic [L-1:0] e_vld;
    bit e_busy;
    e_out  = '0;
    e_busy = (q.size() != 0);
    for (int i = 0; i < L; i++) begin
      e_vld[i] = pv[i];
      if (pv[i]) begin
        e_out[i*8 +: 8] = pr[i][i*8 +: 8];
        e_busy = 1'b1;
      end
    end
    chk("count",   COUNT, q.size());
    chk("d_valid", D_VALID, e_vld);
    chk("d_out",   D_out, e_out);
    chk("empty",   IS_EMPTY, q.size() == 0);
    chk("full",    IS_FULL, q.size() == D);
    chk("afull",   ALMOST_FULL, q.size() >= D - 2);
    chk("busy",    BUSY, e_busy);
`ifdef SA_SKEW_FIFO_ERR_EN
    chk("err_ovf", ERR_OVF, m_ovf);
    chk("err_udf", ERR_UDF, m_udf);
`else
    chk("err_ovf", ERR_OVF, 1'b0);
    chk("err_udf", ERR_UDF, 1'b0);
`endif
  endtask

  task automatic cyc(input bit push, input logic [31:0] din, input bit pop, input bit flush);
    bit pop_ok, push_ok;
    logic [31:0] r;
    PUSHE = push; D_in = din; POPE = pop; FLUSH = flush;
    pop_ok  = pop && (q.size() != 0);
    push_ok = push && ((q.size() < D) || pop_ok);
    if (push && q.size() == D && !pop_ok) m_ovf = 1'b1;
    if (pop && q.size() == 0) m_udf = 1'b1;
    @(posedge CLK);
    for (int i = L - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pr[i] = pr[i-1];
    end
    if (flush) begin
      model_clear();
    end else begin
      r = '0;
      if (pop_ok) r = q.pop_front();
      if (push_ok) q.push_back(din);
      pv[0] = pop_ok;
      pr[0] = r;
    end
    #1;
    PUSHE = 1'b0; POPE = 1'b0; FLUSH = 1'b0; D_in = '0;
    check_all();
  endtask

  initial begin
    RSTn = 1'b0; FLUSH = 1'b0; PUSHE = 1'b0; POPE = 1'b0; D_in = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    model_clear();
    #12;
    chk("rst_count", COUNT, 6'd0);
    chk("rst_empty", IS_EMPTY, 1'b1);
    chk("rst_dvalid", D_VALID, 4'h0);
    chk("rst_dout", D_out, 32'h0);
    chk("rst_busy", BUSY, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) cyc(0, '0, 0, 0);

    // Skew order: one row, lane i = 0x10+i, walks the diagonal.
    cyc(1, row(32'h10), 0, 0);
    cyc(0, '0, 1, 0);
    chk("skew0_v", D_VALID, 4'b0001); chk("skew0_d", D_out, 32'h0000_0010);
    cyc(0, '0, 0, 0);
    chk("skew1_v", D_VALID, 4'b0010); chk("skew1_d", D_out, 32'h0000_1100);
    cyc(0, '0, 0, 0);
    chk("skew2_v", D_VALID, 4'b0100); chk("skew2_d", D_out, 32'h0012_0000);
    cyc(0, '0, 0, 0);
    chk("skew3_v", D_VALID, 4'b1000); chk("skew3_d", D_out, 32'h1300_0000);
    chk("skew3_busy", BUSY, 1'b1);
    cyc(0, '0, 0, 0);
    chk("skew4_v", D_VALID, 4'b0000); chk("skew4_busy", BUSY, 1'b0);

    // Pop while empty with a same-cycle push: no bypass.
    cyc(1, row(32'h40), 1, 0);
    chk("epop_count", COUNT, 6'd1); chk("epop_v", D_VALID, 4'b0000);
    cyc(0, '0, 1, 0);
    chk("epop_drain", D_out, 32'h0000_0040);
    repeat (4) cyc(0, '0, 0, 0);

    // Fill to full, then an overflow push.
    for (int k = 0; k < D; k++) begin
      cyc(1, row(k), 0, 0);
      if (k == 28) chk("af_29", ALMOST_FULL, 1'b0);
      if (k == 29) chk("af_30", ALMOST_FULL, 1'b1);
    end
    chk("full_flag", IS_FULL, 1'b1); chk("full_count", COUNT, 6'd32);
    cyc(1, row(99), 0, 0);
    chk("ovf_count", COUNT, 6'd32);

    // Full with simultaneous push and pop, then stream everything out.
    cyc(1, row(100), 1, 0);
    chk("fpp_count", COUNT, 6'd32); chk("fpp_d", D_out, 32'h0000_0000);
    chk("fpp_v", D_VALID, 4'b0001);
    for (int j = 0; j < D; j++) cyc(1, row(150 + j), 1, 0);
    for (int j = 0; j < D; j++) cyc(0, '0, 1, 0);
    repeat (4) cyc(0, '0, 0, 0);
    chk("drain_busy", BUSY, 1'b0);

    // Flush mid-stream beats same-cycle push/pop.
    for (int k = 0; k < 5; k++) cyc(1, row(32'h60 + 16 * k), 0, 0);
    repeat (3) cyc(0, '0, 1, 0);
    cyc(1, row(32'h77), 1, 1);
    chk("flush_v", D_VALID, 4'b0000); chk("flush_count", COUNT, 6'd0);
    chk("flush_busy", BUSY, 1'b0);
    repeat (2) cyc(0, '0, 0, 0);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 5; k++) cyc(1, row(32'hA0 + 8 * k), 0, 0);
    repeat (3) cyc(0, '0, 1, 0);
    #2 RSTn = 1'b0;
    #1;
    m_ovf = 1'b0; m_udf = 1'b0;
    model_clear();
    chk("arst_v", D_VALID, 4'b0000); chk("arst_count", COUNT, 6'd0);
    chk("arst_busy", BUSY, 1'b0); chk("arst_dout", D_out, 32'h0);
    check_all();
    @(negedge CLK);
    RSTn = 1'b1;
    cyc(1, row(5), 0, 0);
    cyc(0, '0, 1, 0);
    repeat (4) cyc(0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
